// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared spiking-network constants, spike event type and wrap-safe time compare
//   TIME_W      : timestep counter / due time width
//   DELAY_W     : axon delay width
//   ID_W        : spike identifier width
//   spike_evt_t : addressed spike event {id, due_time}
//   time_reached: true once 'now' has reached or passed 'due' in modular time
package snn_pkg;

    localparam int TIME_W  = 16;
    localparam int DELAY_W = 8;
    localparam int ID_W    = 8;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [TIME_W-1:0] due_time;
    } spike_evt_t;

    // Operands are zero-extended to 32 bits by the caller; the low 'width'
    // bits of the 32-bit difference equal the modular difference, so the
    // sign bit of a width-bit counter is bit (width-1) of the result.
    function automatic logic time_reached(input logic [31:0] now,
                                          input logic [31:0] due,
                                          input int          width);
        logic [31:0] diff;
        logic [31:0] sh;
        diff = now - due;
        sh   = diff >> (width - 1);
        return ~sh[0];
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// rtl/spike_fifo.sv - synchronous FIFO with flush and push-while-full when popping
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : empties the FIFO on the next edge (wins over push/pop)
//   push, wdata   : write request and data (accepted if not full, or full with pop)
//   pop, rdata    : read request, head-of-queue data (valid while !empty)
//   full, empty   : occupancy flags
//   count         : current occupancy, 0..DEPTH
module spike_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import snn_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees the slot before the push claims one, so a full FIFO can
    // still accept a write on the same edge it is read.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axon_delay_queue.sv
// rtl/axon_delay_queue.sv - delays soma fire pulses by the axon delay and emits addressed spikes
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : global timestep strobe
//   kill         : neuron disable; flushes in-flight spikes, ignores fires
//   axon_delay   : delay in timesteps, captured while rst is high
//   fire         : one-cycle fire pulse from the soma
//   spike_valid/spike_ready/spike_id/spike_time : spike event handshake to the router
//   q_count      : in-flight spike count
//   overflow     : sticky, a fire was dropped on a full queue
//   drop_cnt     : saturating count of dropped fires
module axon_delay_queue #(
    parameter int NEURON_ID = 0,
    parameter int ID_W      = snn_pkg::ID_W,
    parameter int TIME_W    = snn_pkg::TIME_W,
    parameter int DELAY_W   = snn_pkg::DELAY_W,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     kill,
    input  logic [DELAY_W-1:0]       axon_delay,
    input  logic                     fire,
    output logic                     spike_valid,
    input  logic                     spike_ready,
    output logic [ID_W-1:0]          spike_id,
    output logic [TIME_W-1:0]        spike_time,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    import snn_pkg::*;

    logic [TIME_W-1:0]  now_q, now_d;
    logic [DELAY_W-1:0] delay_q;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TIME_W-1:0]  fifo_due, push_due;
    logic               head_due;
    logic               dropped;

    // Delay is fixed between resets, so entries are pushed in due order and
    // the head is always the earliest one to release.
    assign push_due = now_q + TIME_W'(delay_q);

    spike_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (kill),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_due),
        .rdata (fifo_due),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    assign head_due    = time_reached(32'(now_q), 32'(fifo_due), TIME_W);
    assign spike_valid = !fifo_empty && head_due && !kill;
    assign spike_time  = fifo_empty ? '0 : fifo_due;
    assign spike_id    = ID_W'(NEURON_ID);

    assign fifo_pop  = spike_valid && spike_ready;
    assign fifo_push = fire && !kill;
    assign dropped   = fire && !kill && fifo_full && !fifo_pop;

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        now_d      = now_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (tick) begin
            now_d = now_q + TIME_W'(1);
        end
        if (dropped) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            now_q      <= now_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Tracks axon_delay for as long as reset is held, then freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q <= axon_delay;
        end
    end

endmodule

// File: tb/tb_axon_delay_queue.sv
// tb/tb_axon_delay_queue.sv - self-checking bench for axon_delay_queue against a queue-based reference model
module tb_axon_delay_queue;
    import snn_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, kill, fire, spike_ready;
    logic [7:0]  axon_delay;
    logic        spike_valid;
    logic [7:0]  spike_id;
    logic [15:0] spike_time;
    logic [3:0]  q_count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    axon_delay_queue #(
        .NEURON_ID (0),
        .ID_W      (8),
        .TIME_W    (16),
        .DELAY_W   (8),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .kill        (kill),
        .axon_delay  (axon_delay),
        .fire        (fire),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_id    (spike_id),
        .spike_time  (spike_time),
        .q_count     (q_count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: timestep number, list of due times in flight, stats.
    int          m_now, m_delay, m_drop;
    bit          m_ovf;
    int          mq[$];
    spike_evt_t  acc_q[$];
    int          acc_cyc[$];
    int          first_valid_now;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        if (kill || mq.size() == 0) return 1'b0;
        return ((m_now - mq[0]) & 'hFFFF) < 32768;
    endfunction

    task automatic model_reset(input int d);
        m_now   = 0;
        m_delay = d;
        m_drop  = 0;
        m_ovf   = 1'b0;
        mq.delete();
        acc_q.delete();
        acc_cyc.delete();
        first_valid_now = -1;
    endtask

    task automatic check_outputs();
        check("spike_valid", 32'(spike_valid), 32'(m_valid()));
        check("spike_time", 32'(spike_time), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        check("q_count", 32'(q_count), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic cycle(input logic f, input logic t, input logic k, input logic r);
        bit vexp;
        fire = f; tick = t; kill = k; spike_ready = r;
        #1;
        check_outputs();
        if (spike_valid === 1'b1 && first_valid_now < 0) first_valid_now = m_now;
        if (spike_valid === 1'b1 && r) begin
            acc_q.push_back('{id: spike_id, due_time: spike_time});
            acc_cyc.push_back(cyc);
        end
        vexp = m_valid();
        if (k) begin
            mq.delete();
        end else begin
            if (vexp && r) void'(mq.pop_front());
            if (f) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back((m_now + m_delay) & 'hFFFF);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        if (t) m_now = (m_now + 1) & 'hFFFF;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        fire = 0; tick = 0; kill = 0; spike_ready = 0;
        axon_delay = 8'(d);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset(d);
        check_outputs();
        rst = 1'b0;
        axon_delay = 8'($urandom);
    endtask

    initial begin
        logic f, t, k, r;
        bit   fired, mono;

        // Delay 3, fire at now=10, ticks every 4 cycles.
        do_reset(3);
        fired = 0;
        for (int c = 0; c < 80; c++) begin
            t = (c % 4 == 3);
            f = (m_now == 10) && !fired && !t;
            if (f) fired = 1;
            cycle(f, t, 1'b0, 1'b1);
        end
        check("t1_accepts", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) begin
            check("t1_time", 32'(acc_q[0].due_time), 32'd13);
            check("t1_id", 32'(acc_q[0].id), 32'd0);
        end
        check("t1_first_valid_now", 32'(first_valid_now), 32'd13);

        // Delay 0: visible the cycle after the fire.
        do_reset(0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_valid_next", 32'(spike_valid), 32'd1);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_accepts", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) check("t2_time", 32'(acc_q[0].due_time), 32'd5);
        check("t2_qcount", 32'(q_count), 32'd0);

        // Overflow: 10 fires into an 8-deep queue, then drain.
        do_reset(5);
        for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_qcount_full", 32'(q_count), 32'd8);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        for (int c = 0; c < 25; c++) cycle(1'b0, 1'(c < 5), 1'b0, 1'b1);
        check("t3_drained", 32'(acc_q.size()), 32'd8);
        if (acc_q.size() == 8) begin
            mono = 1;
            for (int i = 1; i < 8; i++)
                if (acc_q[i].due_time < acc_q[i-1].due_time) mono = 0;
            check("t3_nondecreasing", 32'(mono), 32'd1);
            check("t3_back_to_back", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
            check("t3_time", 32'(acc_q[7].due_time), 32'd5);
        end

        // Wrap-around: fire at now=65534 with delay 4.
        do_reset(4);
        fire = 0; kill = 0; spike_ready = 0; tick = 1;
        repeat (65534) @(posedge clk);
        #1;
        m_now = 65534;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 30; c++) cycle(1'b0, 1'(c % 3 == 2), 1'b0, 1'b1);
        check("t4_accepts", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) check("t4_time", 32'(acc_q[0].due_time), 32'd2);
        check("t4_first_valid_now", 32'(first_valid_now), 32'd2);

        // Backpressure: due spike held for 6 cycles with ready low.
        do_reset(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'(c % 2), 1'b0, 1'b0);
            check("t5_hold_valid", 32'(spike_valid), 32'd1);
            check("t5_hold_time", 32'(spike_time), 32'd2);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_accepts", 32'(acc_q.size()), 32'd1);

        // Kill flush, then asynchronous reset mid-flight.
        do_reset(6);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_kill_valid", 32'(spike_valid), 32'd0);
        check("t6_kill_qcount", 32'(q_count), 32'd0);
        check("t6_kill_drop", 32'(drop_cnt), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("t6_resume_qcount", 32'(q_count), 32'd2);
        fire = 0; tick = 0; kill = 0; spike_ready = 1;
        axon_delay = 8'd6;
        #2;
        rst = 1'b1;
        #1;
        model_reset(6);
        check_outputs();
        check("t6_rst_valid", 32'(spike_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 30; c++) cycle(1'b0, 1'(c % 2), 1'b0, 1'b1);
        check("t6_no_late_spikes", 32'(acc_q.size()), 32'd0);

        // Randomized traffic against the reference model.
        do_reset(int'($urandom_range(0, 6)));
        for (int c = 0; c < 600; c++) begin
            f = ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(f, t, k, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
